// File: rtl/vx_pick_stage_if.sv
// Request/pick bundle for vx_pick_stage: N request lanes in, one registered pick out.
// Carries no logic or storage.
// The valid/ready handshakes are on both sides; the slave side is the pick stage itself.
interface vx_pick_stage_if #(
    parameter int N     = 4,
    parameter int DATAW = 8
);
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]       valid_in;
    logic [N*DATAW-1:0] data_in;
    logic [N-1:0]       ready_in;
    logic               valid_out;
    logic [DATAW-1:0]   data_out;
    logic [IDXW-1:0]    index_out;
    logic               ready_out;

    // Request producers and pick consumer
    modport master (
        output valid_in, data_in, ready_out,
        input  ready_in, valid_out, data_out, index_out
    );

    // The pick stage
    modport slave (
        input  valid_in, data_in, ready_out,
        output ready_in, valid_out, data_out, index_out
    );
endinterface

// File: rtl/vx_pick_stage.sv
// Registered first-valid arbiter: picks one of N lanes per cycle into an output register.
// Latency 1 cycle from valid_in to valid_out; full throughput (drain and refill in one cycle).
// Stalls all lanes (ready_in=0) while the held pick is not taken; VX_PICK_STAGE_ROTATE_EN selects round-robin.
module vx_pick_stage #(
    parameter int N       = 4,
    parameter int DATAW   = 8,
    parameter int REVERSE = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    vx_pick_stage_if.slave pick
);
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    logic               any_valid;
    logic               accept;
    logic [IDXW-1:0]    sel;
    logic [DATAW-1:0]   sel_data;
    logic               full;
    logic               full_next;
    logic [DATAW-1:0]   data_q;
    logic [IDXW-1:0]    index_q;
    logic [N-1:0]       ack;

`ifdef VX_PICK_STAGE_ROTATE_EN
    logic [IDXW-1:0]    ptr;
    logic [IDXW-1:0]    ptr_next;
`endif

    // Gated by reset_n so no lane is ever acked while the stage is held in reset
    assign any_valid = |pick.valid_in;
    assign accept    = reset_n & any_valid & (~full | pick.ready_out);

    // Priority scan: walk lanes in scan order from the base lane, take the first valid one
    always_comb begin : scan
        int     base;
        int     lane;
        logic   found;
        sel      = '0;
        sel_data = '0;
        found    = 1'b0;
        lane     = 0;
`ifdef VX_PICK_STAGE_ROTATE_EN
        base     = int'(ptr);
`else
        base     = (REVERSE != 0) ? (N - 1) : 0;
`endif
        for (int i = 0; i < N; i++) begin
            lane = (REVERSE != 0) ? ((base - i + N) % N) : ((base + i) % N);
            if (!found && pick.valid_in[lane]) begin
                found    = 1'b1;
                sel      = IDXW'(lane);
                sel_data = pick.data_in[lane*DATAW +: DATAW];
            end
        end
    end

    // One-hot ack to the winning lane, only on cycles the output register loads
    always_comb begin : ack_gen
        ack = '0;
        for (int i = 0; i < N; i++) begin
            ack[i] = accept && (sel == IDXW'(i));
        end
    end

    // EMPTY/FULL next state: load wins over drain, drain only when consumer takes it
    always_comb begin : full_ns
        full_next = full;
        if (accept) begin
            full_next = 1'b1;
        end else if (pick.ready_out) begin
            full_next = 1'b0;
        end
    end

    // EMPTY/FULL state register
    always_ff @(posedge clk or negedge reset_n) begin : full_reg
        if (!reset_n) begin
            full <= 1'b0;
        end else begin
            full <= full_next;
        end
    end

    // Pick payload and index; held unchanged unless a new pick is accepted
    always_ff @(posedge clk or negedge reset_n) begin : pick_reg
        if (!reset_n) begin
            data_q  <= '0;
            index_q <= '0;
        end else if (accept) begin
            data_q  <= sel_data;
            index_q <= sel;
        end
    end

`ifdef VX_PICK_STAGE_ROTATE_EN
    // Next scan start is the neighbour of the winner, wrapping at N rather than 2**IDXW
    always_comb begin : ptr_ns
        ptr_next = ptr;
        if (REVERSE != 0) begin
            ptr_next = (sel == '0) ? IDXW'(N - 1) : (sel - IDXW'(1));
        end else begin
            ptr_next = (sel == IDXW'(N - 1)) ? '0 : (sel + IDXW'(1));
        end
    end

    // Round-robin pointer advances only on accept
    always_ff @(posedge clk or negedge reset_n) begin : ptr_reg
        if (!reset_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= ptr_next;
        end
    end
`endif

    // Output drive
    always_comb begin : out_drv
        pick.ready_in  = ack;
        pick.valid_out = full;
        pick.data_out  = data_q;
        pick.index_out = index_q;
    end

endmodule
